fft_acc_ram_dp: RTL and testbench

FFT_ACC_RAM_DP -- requirements
Module: fft_acc_ram_dp

---
 rtl/fft_acc_ram_dp.sv | 150 +++++++++++++++
 tb/tb_fft_acc_ram_dp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_acc_ram_dp.sv
// Dual-port Avalon-MM byte-enabled RAM with a sequential clear engine, s1-wins write
// arbitration and a sticky collision flag.
module fft_acc_ram_dp #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                clear_req,
    output logic                busy,
    output logic                collision,

    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,

    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {StClear, StRun} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                collision_q, collision_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                s1_wr, s2_wr_raw, s2_wr, collide;
    logic [1:0]          rd_acc;
    logic [DATA_W-1:0]   rd_word [2];
    logic [1:0]          p_valid, o_valid;
    logic [DATA_W-1:0]   p_data [2];
    logic [DATA_W-1:0]   o_data [2];

    assign busy           = (state_q == StClear);
    assign collision      = collision_q;
    assign s1_waitrequest = busy | ~clken;
    assign s2_waitrequest = busy | ~clken;

    // A read sharing a cycle with a write on the same port is not issued.
    assign s1_wr     = s1_chipselect & s1_write & ~s1_waitrequest;
    assign s2_wr_raw = s2_chipselect & s2_write & ~s2_waitrequest;
    assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
    assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;
    assign collide   = s1_wr & s2_wr_raw & (s1_address == s2_address);
    assign s2_wr     = s2_wr_raw & ~collide;

    assign rd_word[0] = mem[s1_address];
    assign rd_word[1] = mem[s2_address];

    // Memory array has no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (clken && reset_n) begin
            if (busy) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (s1_wr && s1_byteenable[b]) mem[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
                    if (s2_wr && s2_byteenable[b]) mem[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
                end
            end
        end
    end

    // Old data is returned on read/write overlap because the array updates via NBA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid <= '0;
            o_valid <= '0;
            for (int p = 0; p < 2; p++) begin
                p_data[p] <= '0;
                o_data[p] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < 2; p++) begin
                if (READ_LATENCY == 2) begin
                    p_valid[p] <= rd_acc[p];
                    if (rd_acc[p]) p_data[p] <= rd_word[p];
                    o_valid[p] <= p_valid[p];
                    if (p_valid[p]) o_data[p] <= p_data[p];
                end else begin
                    o_valid[p] <= rd_acc[p];
                    if (rd_acc[p]) o_data[p] <= rd_word[p];
                end
            end
        end
    end

    assign s1_readdata      = o_data[0];
    assign s1_readdatavalid = o_valid[0];
    assign s2_readdata      = o_data[1];
    assign s2_readdatavalid = o_valid[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        collision_d = collision_q;
        if (clken) begin
            unique case (state_q)
                StClear: begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) state_d = StRun;
                end
                StRun: begin
                    if (collide) collision_d = 1'b1;
                    // Starting a clear wins over a same-cycle collision.
                    if (clear_req) begin
                        state_d     = StClear;
                        cnt_d       = '0;
                        collision_d = 1'b0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_acc_ram_dp.sv
// Directed self-checking bench: default instance plus a small READ_LATENCY=2 instance.
module tb_fft_acc_ram_dp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset_n, clken, clear_req, busy, collision;
    logic [9:0]  s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

    fft_acc_ram_dp dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .clear_req(clear_req),
        .busy(busy), .collision(collision),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest(s2_waitrequest)
    );

    logic        b_reset_n, b_busy, b_collision;
    logic [3:0]  b_s2_address;
    logic        b_s2_chipselect, b_s2_read, b_s2_write;
    logic [31:0] b_s2_writedata, b_s2_readdata, b_s1_readdata;
    logic        b_s2_readdatavalid, b_s2_waitrequest, b_s1_readdatavalid, b_s1_waitrequest;

    fft_acc_ram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(b_reset_n), .clken(1'b1), .clear_req(1'b0),
        .busy(b_busy), .collision(b_collision),
        .s1_address(4'd0), .s1_chipselect(1'b0), .s1_read(1'b0), .s1_write(1'b0),
        .s1_byteenable(4'hF), .s1_writedata(32'd0), .s1_readdata(b_s1_readdata),
        .s1_readdatavalid(b_s1_readdatavalid), .s1_waitrequest(b_s1_waitrequest),
        .s2_address(b_s2_address), .s2_chipselect(b_s2_chipselect), .s2_read(b_s2_read),
        .s2_write(b_s2_write), .s2_byteenable(4'hF), .s2_writedata(b_s2_writedata),
        .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
        .s2_waitrequest(b_s2_waitrequest)
    );

    task automatic wr1(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
        @(negedge clk);
        s1_chipselect = 0; s1_write = 0;
    endtask

    task automatic rd1(input logic [9:0] a, output logic v, output logic [31:0] d);
        s1_chipselect = 1; s1_read = 1; s1_address = a;
        @(negedge clk);
        v = s1_readdatavalid; d = s1_readdata;
        s1_chipselect = 0; s1_read = 0;
    endtask

    task automatic pulse_clear();
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        checks++; if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b exp 00", s1_readdatavalid, s2_readdatavalid); end
        checks++; if (s1_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", s1_readdata); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll got %b exp 0", collision); end
        checks++; if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got %b exp 1", s1_waitrequest); end
    endtask

    task automatic test_clear_after_reset();
        int n;
        logic v;
        logic [31:0] d;
        reset_n = 1;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        checks++; if (n != 1024) begin errors++; $display("FAIL init_clear_len got %0d exp 1024", n); end
        checks++; if (s1_waitrequest !== 1'b0) begin errors++; $display("FAIL run_wait got %b exp 0", s1_waitrequest); end
        rd1(10'd5, v, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rd5 got v=%b d=%h exp v=1 d=0", v, d); end
        @(negedge clk);
        checks++; if (s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd5_pulse got %b exp 0", s1_readdatavalid); end
    endtask

    task automatic test_byteenable();
        logic v;
        logic [31:0] d;
        wr1(10'd3, 32'h11223344, 4'hF);
        wr1(10'd3, 32'hAABBCCDD, 4'b0101);
        rd1(10'd3, v, d);
        checks++; if (v !== 1'b1 || d !== 32'h11BB33DD) begin errors++; $display("FAIL byteen got v=%b d=%h exp v=1 d=11bb33dd", v, d); end
        @(negedge clk);
        checks++; if (s1_readdata !== 32'h11BB33DD) begin errors++; $display("FAIL rdata_hold got %h exp 11bb33dd", s1_readdata); end
    endtask

    task automatic test_same_port_rw();
        logic v;
        logic [31:0] d;
        s1_chipselect = 1; s1_read = 1; s1_write = 1; s1_address = 10'd10;
        s1_writedata = 32'h00000077; s1_byteenable = 4'hF;
        @(negedge clk);
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        checks++; if (s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_noread got %b exp 0", s1_readdatavalid); end
        rd1(10'd10, v, d);
        checks++; if (d !== 32'h77) begin errors++; $display("FAIL rw_write got %h exp 77", d); end
    endtask

    task automatic test_old_data();
        logic v;
        logic [31:0] d;
        s1_chipselect = 1; s1_read = 1; s1_address = 10'd9;
        s2_chipselect = 1; s2_write = 1; s2_address = 10'd9; s2_writedata = 32'h55; s2_byteenable = 4'hF;
        @(negedge clk);
        s1_chipselect = 0; s1_read = 0; s2_chipselect = 0; s2_write = 0;
        checks++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h0) begin
            errors++; $display("FAIL old_data got v=%b d=%h exp v=1 d=0", s1_readdatavalid, s1_readdata); end
        rd1(10'd9, v, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL s2_write got %h exp 55", d); end
    endtask

    task automatic test_collision();
        logic v;
        logic [31:0] d;
        int n;
        s1_chipselect = 1; s1_write = 1; s1_address = 10'd7; s1_writedata = 32'h1; s1_byteenable = 4'hF;
        s2_chipselect = 1; s2_write = 1; s2_address = 10'd7; s2_writedata = 32'h2; s2_byteenable = 4'hF;
        @(negedge clk);
        s1_chipselect = 0; s1_write = 0; s2_chipselect = 0; s2_write = 0;
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_set got %b exp 1", collision); end
        rd1(10'd7, v, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL coll_win got %h exp 1", d); end
        repeat (4) @(negedge clk);
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b exp 1", collision); end
        pulse_clear();
        checks++; if (collision !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL coll_clear got coll=%b busy=%b exp 0 1", collision, busy); end
        n = 0;
        while (busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        checks++; if (n != 1024) begin errors++; $display("FAIL req_clear_len got %0d exp 1024", n); end
    endtask

    task automatic test_clken_freeze();
        int n, guard;
        bit froze;
        pulse_clear();
        n = 0; guard = 0; froze = 0;
        while (busy === 1'b1 && guard < 5000) begin
            if (n == 100 && !froze) begin
                clken = 0;
                clear_req = 1;
                repeat (3) begin
                    @(negedge clk);
                    clear_req = 0;
                    checks++; if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
                        errors++; $display("FAIL freeze_wait got %b%b exp 11", s1_waitrequest, s2_waitrequest); end
                end
                checks++; if (dut.cnt_q !== 10'd100) begin errors++; $display("FAIL freeze_cnt got %0d exp 100", dut.cnt_q); end
                clken = 1;
                froze = 1;
            end
            n++; guard++;
            @(negedge clk);
        end
        checks++; if (n != 1024 || !froze) begin errors++; $display("FAIL freeze_len got %0d exp 1024", n); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic v;
        logic [31:0] d;
        wr1(10'd600, 32'hDEAD, 4'hF);
        pulse_clear();
        n = 0;
        while (busy === 1'b1 && n < 512) begin n++; @(negedge clk); end
        checks++; if (dut.cnt_q !== 10'd512) begin errors++; $display("FAIL pre_rst_cnt got %0d exp 512", dut.cnt_q); end
        reset_n = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || dut.cnt_q !== 10'd0) begin
            errors++; $display("FAIL mid_rst got busy=%b cnt=%0d exp 1 0", busy, dut.cnt_q); end
        reset_n = 1;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        checks++; if (n != 1024) begin errors++; $display("FAIL restart_len got %0d exp 1024", n); end
        rd1(10'd600, v, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rd600 got v=%b d=%h exp 1 0", v, d); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp_d [3];
        n = 0;
        while (b_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (n != 16) begin errors++; $display("FAIL b_clear_len got %0d exp 16", n); end
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 32'hA0 + 32'(i);
            b_s2_chipselect = 1; b_s2_write = 1; b_s2_address = 4'(i); b_s2_writedata = exp_d[i];
            @(negedge clk);
        end
        b_s2_write = 0; b_s2_read = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) b_s2_address = 4'(i);
            else begin b_s2_read = 0; b_s2_chipselect = 0; end
            @(negedge clk);
            if (i == 0 || i == 4) begin
                checks++; if (b_s2_readdatavalid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_%0d got %b exp 0", i, b_s2_readdatavalid); end
            end else if (i < 4) begin
                checks++; if (b_s2_readdatavalid !== 1'b1 || b_s2_readdata !== exp_d[i-1]) begin
                    errors++; $display("FAIL b2b_%0d got v=%b d=%h exp 1 %h", i, b_s2_readdatavalid, b_s2_readdata, exp_d[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        b_s2_chipselect = 1; b_s2_read = 1; b_s2_address = 4'd1;
        @(negedge clk);
        b_s2_chipselect = 0; b_s2_read = 0;
        b_reset_n = 0;
        #1;
        seen = b_s2_readdatavalid;
        @(negedge clk);
        b_reset_n = 1;
        repeat (3) begin
            @(negedge clk);
            seen = seen | b_s2_readdatavalid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", seen); end
        checks++; if (b_s2_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", b_s2_readdata); end
    endtask

    initial begin
        reset_n = 0; b_reset_n = 0; clken = 1; clear_req = 0;
        s1_address = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_byteenable = '0; s1_writedata = '0;
        s2_address = '0; s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_byteenable = '0; s2_writedata = '0;
        b_s2_address = '0; b_s2_chipselect = 0; b_s2_read = 0; b_s2_write = 0; b_s2_writedata = '0;
        test_reset();
        b_reset_n = 1;
        test_back_to_back();
        test_reset_mid_read();
        test_clear_after_reset();
        test_byteenable();
        test_same_port_rw();
        test_old_data();
        test_collision();
        test_clken_freeze();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
